serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor computing a - b modulo 2^WIDTH, one bit
//   per clock, LSB first, using a single full-subtractor cell.
//
//   Optional feature: define SUB_FLAGS_EN to build the zero/negative/overflow
//   status flags. Without it those outputs are tied to 0.
//
//   Ports
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset
//     start     in   request a subtraction (accepted in IDLE or DONE)
//     a, b      in   minuend / subtrahend, captured when start is accepted
//     busy      out  subtraction in progress
//     done      out  one-cycle pulse, result and flags valid
//     result    out  a - b modulo 2^WIDTH
//     borrow    out  final borrow-out (a < b unsigned)
//     zero      out  result == 0
//     negative  out  result MSB
//     overflow  out  signed overflow of the subtraction
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | processing one bit per cycle, WIDTH cycles
//   DONE  | one-cycle done pulse; start here re-enters RUN directly
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    bit_cnt;
    logic             bin;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_final;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign d    = a_sh[0] ^ b_sh[0] ^ bin;
    assign bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);

    // Complete difference as it will look after the final bit is shifted in.
    assign res_final = {d, acc[WIDTH-1:1]};
    assign last_bit  = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bin     <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            result  <= '0;
            borrow  <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            bit_cnt <= '0;
            bin     <= 1'b0;
        end else if (busy) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            acc     <= res_final;
            bin     <= bout;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            // Outputs change only when the last bit is done, never mid-run.
            if (last_bit) begin
                result <= res_final;
                borrow <= bout;
            end
        end
    end

`ifdef SUB_FLAGS_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // Operand sign bits are kept aside because a_sh/b_sh shift them out.
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (busy && last_bit) begin
                zero     <= (res_final == '0);
                negative <= d;
                overflow <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end
`else
    assign zero     = 1'b0;
    assign negative = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule
